// File: rtl/bist_misr_ctrl_pkg.sv
// Shared types for the BIST controller: FSM state encoding and the LFSR seed
// value the pattern generator loads while its reset input is held high.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    CMP,
    DONE
  } state_e;

  localparam logic [2:0] LFSR_SEED = 3'b111;

endpackage

// File: rtl/bist_misr_ctrl_misr.sv
// Multiple-input signature register: shifts right with parity feedback into
// the MSB and folds in one response word per enabled cycle.
module misr_core #(
  parameter int              WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS = 3'b101
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] resp_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q, sig_d;
  logic             fb;

  // Clear wins over enable so a seed cycle always starts from zero.
  always_comb begin
    fb    = ^(sig_q & TAPS);
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {fb, sig_q[WIDTH-1:1]} ^ resp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST sequencer: seeds the LFSR, compacts N_PATTERNS CUT responses into a
// MISR and compares against a golden signature. Define BIST_TWO_POLY_EN for a
// second run with Poly=1 checked against GOLDEN1.
module bist_misr_ctrl #(
  parameter int               WIDTH      = 3,
  parameter int               N_PATTERNS = 7,
  parameter logic [WIDTH-1:0] TAPS       = 3'b101,
  parameter logic             POLY_SEL   = 1'b0,
  parameter logic [WIDTH-1:0] GOLDEN0    = '0,
  parameter logic [WIDTH-1:0] GOLDEN1    = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] Resp,
  output logic             Lfsr_rst,
  output logic             Poly,
  output logic [WIDTH-1:0] Sig,
  output logic             Busy,
  output logic             Done,
  output logic             Pass
);

  import bist_pkg::*;

  localparam int            CW       = $clog2(N_PATTERNS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_PATTERNS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pass_q, pass_d;
  logic          misr_clr, misr_en;
`ifdef BIST_TWO_POLY_EN
  logic          poly_q, poly_d;
  logic          pass0_q, pass0_d;
`endif

  misr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_misr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .resp_i (Resp),
    .sig_o  (Sig)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    Lfsr_rst = 1'b1;
    Busy     = 1'b0;
    Done     = 1'b0;
`ifdef BIST_TWO_POLY_EN
    poly_d   = poly_q;
    pass0_d  = pass0_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SEED;
`ifdef BIST_TWO_POLY_EN
          poly_d  = 1'b0;
`endif
        end
      end
      SEED: begin
        Busy     = 1'b1;
        misr_clr = 1'b1;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        Busy     = 1'b1;
        Lfsr_rst = 1'b0;
        misr_en  = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = CMP;
        end
      end
      CMP: begin
        Busy = 1'b1;
`ifdef BIST_TWO_POLY_EN
        // First compare only records the Poly=0 verdict and re-seeds for Poly=1.
        if (!poly_q) begin
          pass0_d = (Sig == GOLDEN0);
          poly_d  = 1'b1;
          state_d = SEED;
        end else begin
          pass_d  = pass0_q & (Sig == GOLDEN1);
          state_d = DONE;
        end
`else
        pass_d  = (Sig == GOLDEN0);
        state_d = DONE;
`endif
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          state_d = SEED;
`ifdef BIST_TWO_POLY_EN
          poly_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
`ifdef BIST_TWO_POLY_EN
      poly_q  <= 1'b0;
      pass0_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
`ifdef BIST_TWO_POLY_EN
      poly_q  <= poly_d;
      pass0_q <= pass0_d;
`endif
    end
  end

  assign Pass = pass_q;
`ifdef BIST_TWO_POLY_EN
  assign Poly = poly_q;
`else
  assign Poly = POLY_SEL;
`endif

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Self-checking bench for bist_misr_ctrl: an edge-count timeline model checked
// every cycle, plus hand-computed signatures, verdicts and latencies.
module tb_bist_misr_ctrl;

  localparam int W = 3;
  localparam int N = 7;
  localparam int P = N + 2;
`ifdef BIST_TWO_POLY_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam logic [W-1:0] TAPS = 3'b101;
  localparam logic [W-1:0] G0   = 3'b000;
  localparam logic [W-1:0] G1   = 3'b010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] resp = '0;
  logic         lrst, poly, busy, done, pass;
  logic [W-1:0] sig;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] vec0 [N];
  logic [W-1:0] vec1 [N];

  always #5 clk = ~clk;

  bist_misr_ctrl #(
    .WIDTH      (W),
    .N_PATTERNS (N),
    .TAPS       (TAPS),
    .POLY_SEL   (1'b0),
    .GOLDEN0    (G0),
    .GOLDEN1    (G1)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .Start    (start),
    .Resp     (resp),
    .Lfsr_rst (lrst),
    .Poly     (poly),
    .Sig      (sig),
    .Busy     (busy),
    .Done     (done),
    .Pass     (pass)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] r);
    logic fb;
    fb = ^(s & TAPS);
    return {fb, s[W-1:1]} ^ r;
  endfunction

  // Model: m_t = edges since the launching edge (-1 = idle). Within a pass of
  // P edges: phase 0 SEED, 1..N RUN, N+1 CMP; m_t == NP*P means DONE.
  int           m_t = -1;
  logic [W-1:0] m_sig = '0;
  logic         m_pass = 1'b0;
  logic         m_pass0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int ph;
    if (!rst_n) begin
      m_t     = -1;
      m_sig   = '0;
      m_pass  = 1'b0;
      m_pass0 = 1'b0;
    end else if (m_t < 0 || m_t >= NP * P) begin
      if (start) m_t = 0;
    end else begin
      ph = m_t % P;
      if (ph == 0) begin
        m_sig = '0;
      end else if (ph <= N) begin
        m_sig = misr_step(m_sig, resp);
      end else begin
        if (m_t / P == 0) m_pass0 = (m_sig == G0);
        if (m_t / P == NP - 1) m_pass = (NP == 1) ? m_pass0 : (m_pass0 && (m_sig == G1));
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    logic e_busy, e_done, e_lrst, e_poly;
    int   ph;
    if (m_t < 0) begin
      e_busy = 1'b0; e_done = 1'b0; e_lrst = 1'b1;
    end else if (m_t >= NP * P) begin
      e_busy = 1'b0; e_done = 1'b1; e_lrst = 1'b1;
    end else begin
      ph     = m_t % P;
      e_busy = 1'b1;
      e_done = 1'b0;
      e_lrst = (ph == 0 || ph == N + 1);
    end
`ifdef BIST_TWO_POLY_EN
    e_poly = (m_t >= P);
`else
    e_poly = 1'b0;
`endif
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("lfsr_rst", 32'(lrst), 32'(e_lrst));
    chk("poly", 32'(poly), 32'(e_poly));
    chk("sig", 32'(sig), 32'(m_sig));
    if (e_done) chk("pass", 32'(pass), 32'(m_pass));
  end

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) begin
      vec0[i] = v;
      vec1[i] = v;
    end
  endtask

  // Launches a run from IDLE/DONE, feeds vec0/vec1 during RUN cycles and
  // returns the edge count from the launching edge until Done (-1 on timeout).
  task automatic do_run(input int pulse_at, output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 3 * NP * P; e++) begin
      int ph, j;
      ph    = (e - 1) % P;
      j     = (e - 1) / P;
      start = (e == pulse_at);
      if (ph >= 1 && ph <= N && j < NP) resp = (j == 0) ? vec0[ph-1] : vec1[ph-1];
      else resp = '0;
      @(negedge clk);
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
    resp  = '0;
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_lfsr_rst", 32'(lrst), 32'd1);
    chk("reset_sig", 32'(sig), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef BIST_TWO_POLY_EN
    fill(3'b000);
    do_run(-1, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_sig", 32'(sig), 32'd0);
    chk("t1_pass", 32'(pass), 32'd1);

    fill(3'b000);
    vec0[0] = 3'b001;
    do_run(-1, lat);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_sig", 32'(sig), 32'b010);
    chk("t2_pass", 32'(pass), 32'd0);

    fill(3'b001);
    do_run(-1, lat);
    chk("t3_sig", 32'(sig), 32'd0);
    chk("t3_pass", 32'(pass), 32'd1);

    fill(3'b000);
    vec0[0] = 3'b001;
    do_run(4, lat);
    chk("t4_latency", 32'(lat), 32'd9);
    chk("t4_sig", 32'(sig), 32'b010);
    chk("t4_pass", 32'(pass), 32'd0);
    repeat (3) @(negedge clk);
`else
    fill(3'b000);
    vec1[0] = 3'b001;
    do_run(-1, lat);
    chk("t6_latency", 32'(lat), 32'd18);
    chk("t6_sig", 32'(sig), 32'b010);
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_poly", 32'(poly), 32'd1);
`endif

    // Abort mid-RUN with an asynchronous reset away from any clock edge.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp  = 3'b011;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_lfsr_rst", 32'(lrst), 32'd1);
    chk("t5_sig", 32'(sig), 32'd0);
    chk("t5_pass", 32'(pass), 32'd0);
    resp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(3'b000);
    do_run(-1, lat);
    chk("t5_rerun_latency", 32'(lat), 32'(NP * P));
    chk("t5_rerun_sig", 32'(sig), 32'd0);
`ifndef BIST_TWO_POLY_EN
    chk("t5_rerun_pass", 32'(pass), 32'd1);
`endif
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
